// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS generator and checker.
// The generator and checker both use lfsr_next so their sequences cannot drift apart.
package lfsr_pkg;

    localparam int unsigned NB_LFSR = 8;

    // Bits that take the feedback XOR; bit 0 receives the feedback directly.
    localparam logic [NB_LFSR-1:0] LFSR_TAPS = 8'h8C;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } chk_state_e;

    // Feedback is XOR-ed with the zero detect on bits [6:0]. This gives a
    // period-256 sequence that passes through the all-zero word.
    function automatic logic [NB_LFSR-1:0] lfsr_next(input logic [NB_LFSR-1:0] x);
        logic fb;
        fb = x[NB_LFSR-1] ^ (x[NB_LFSR-2:0] == '0);
        return {x[NB_LFSR-2:0], fb} ^ (LFSR_TAPS & {NB_LFSR{fb}});
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Word stream input and status outputs of the PRBS checker.
interface lfsr_checker_if #(
    parameter int unsigned NB_ERR_CNT = 16
);
    import lfsr_pkg::*;

    logic                  i_valid;
    logic [NB_LFSR-1:0]    i_lfsr;
    logic                  i_clr_cnt;
    logic                  o_lock;
    logic                  o_err;
    logic [NB_ERR_CNT-1:0] o_err_count;
    logic [NB_ERR_CNT-1:0] o_bit_err_count;

    modport master (
        output i_valid, i_lfsr, i_clr_cnt,
        input  o_lock, o_err, o_err_count, o_bit_err_count
    );

    modport slave (
        input  i_valid, i_lfsr, i_clr_cnt,
        output o_lock, o_err, o_err_count, o_bit_err_count
    );

endinterface

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with a variable increment and a synchronous clear.
// When clear and increment happen in the same cycle, the increment is applied to zero.
module lfsr_sat_counter #(
    parameter int unsigned NB_CNT = 16,
    parameter int unsigned NB_INC = 1
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc_en,
    input  logic [NB_INC-1:0] i_inc,
    output logic [NB_CNT-1:0] o_count
);

    localparam int unsigned NB_SUM = NB_CNT + 1;

    logic [NB_CNT-1:0] base;
    logic [NB_SUM-1:0] sum;
    logic [NB_CNT-1:0] count_d;

    // The carry-out of the widened sum marks an overflow; pin the count at all-ones.
    always_comb begin
        base    = i_clr ? '0 : o_count;
        sum     = NB_SUM'(base) + NB_SUM'(i_inc);
        count_d = base;
        if (i_inc_en) begin
            count_d = sum[NB_SUM-1] ? '1 : sum[NB_CNT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_count <= '0;
        end else begin
            o_count <= count_d;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: locks onto the received word stream, then
// flywheels a local prediction and counts mismatches. LFSR_CHECK_BITERR_EN adds the bit-error counter.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 5,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned NB_ERR_CNT   = 16
) (
    input  logic          clk,
    input  logic          i_rst,
    lfsr_checker_if.slave bus
);

    localparam int unsigned NB_RUN = 4;

    chk_state_e         state_q, state_d;
    logic [NB_LFSR-1:0] pred_q, pred_d;
    logic [NB_RUN-1:0]  good_q, good_d;
    logic [NB_RUN-1:0]  bad_q, bad_d;
    logic               match;
    logic               err_hit;
    logic               lock_d;

    assign match = (bus.i_lfsr == pred_q);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_UNLOCKED;
            pred_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    // Reseed from the input until lock; once locked, run on the prediction only.
    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (bus.i_valid) begin
            case (state_q)
                ST_UNLOCKED: begin
                    pred_d  = lfsr_next(bus.i_lfsr);
                    good_d  = '0;
                    state_d = ST_LOCKING;
                end
                ST_LOCKING: begin
                    pred_d = lfsr_next(bus.i_lfsr);
                    if (match) begin
                        good_d = good_q + NB_RUN'(1);
                        if (good_d == NB_RUN'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    pred_d = lfsr_next(pred_q);
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        bad_d = bad_q + NB_RUN'(1);
                        if (bad_d == NB_RUN'(UNLOCK_COUNT)) begin
                            state_d = ST_UNLOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
    end

    always_comb begin
        err_hit = bus.i_valid && (state_q == ST_LOCKED) && !match;
        lock_d  = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            bus.o_lock <= 1'b0;
            bus.o_err  <= 1'b0;
        end else begin
            bus.o_lock <= lock_d;
            bus.o_err  <= err_hit;
        end
    end

    lfsr_sat_counter #(
        .NB_CNT (NB_ERR_CNT),
        .NB_INC (1)
    ) u_err_cnt (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_clr    (bus.i_clr_cnt),
        .i_inc_en (err_hit),
        .i_inc    (1'b1),
        .o_count  (bus.o_err_count)
    );

`ifdef LFSR_CHECK_BITERR_EN
    localparam int unsigned NB_POP = $clog2(NB_LFSR + 1);

    logic [NB_POP-1:0] bit_err_pop;

    assign bit_err_pop = NB_POP'($countones(bus.i_lfsr ^ pred_q));

    lfsr_sat_counter #(
        .NB_CNT (NB_ERR_CNT),
        .NB_INC (NB_POP)
    ) u_bit_err_cnt (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_clr    (bus.i_clr_cnt),
        .i_inc_en (err_hit),
        .i_inc    (bit_err_pop),
        .o_count  (bus.o_bit_err_count)
    );
`else
    assign bus.o_bit_err_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a reference model pushes the expected outputs
// of every driven cycle into a scoreboard, and each entry is checked one cycle later.
module tb_lfsr_checker;

    localparam int unsigned NB = 4;
    localparam int          CMAX = 15;

    typedef struct packed {
        logic          lock;
        logic          err;
        logic [NB-1:0] cnt;
        logic [NB-1:0] bcnt;
    } exp_t;

    logic clk = 1'b0;
    logic i_rst;
    always #5 clk = ~clk;

    lfsr_checker_if #(.NB_ERR_CNT(NB)) bus ();

    lfsr_checker #(
        .LOCK_COUNT   (5),
        .UNLOCK_COUNT (3),
        .NB_ERR_CNT   (NB)
    ) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    exp_t       sb[$];
    int         m_state, m_good, m_bad, m_cnt, m_bcnt;
    logic [7:0] m_pred;
    logic [7:0] w;

    function automatic logic [7:0] ref_next(input logic [7:0] x);
        logic       fb;
        logic [7:0] y;
        fb   = x[7] ^ (x[6:0] == 7'd0);
        y[0] = fb;
        y[1] = x[0];
        y[2] = x[1] ^ fb;
        y[3] = x[2] ^ fb;
        y[4] = x[3];
        y[5] = x[4];
        y[6] = x[5];
        y[7] = x[6] ^ fb;
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] wd, input logic c,
                        input string tag);
        exp_t e;
        bit   counted;
        int   pc;
        @(negedge clk);
        i_rst         = r;
        bus.i_valid   = v;
        bus.i_lfsr    = wd;
        bus.i_clr_cnt = c;
        counted = 1'b0;
        if (r) begin
            m_state = 0; m_pred = 8'h00; m_good = 0; m_bad = 0; m_cnt = 0; m_bcnt = 0;
        end else begin
            counted = v && (m_state == 2) && (wd != m_pred);
            pc = $countones(wd ^ m_pred);
            if (c) begin
                m_cnt = 0; m_bcnt = 0;
            end
            if (counted) begin
                m_cnt  = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                m_bcnt = (m_bcnt + pc > CMAX) ? CMAX : m_bcnt + pc;
            end
            if (v) begin
                case (m_state)
                    0: begin
                        m_pred = ref_next(wd); m_good = 0; m_state = 1;
                    end
                    1: begin
                        if (wd == m_pred) begin
                            m_good++;
                            if (m_good == 5) begin
                                m_state = 2; m_bad = 0;
                            end
                        end else begin
                            m_good = 0;
                        end
                        m_pred = ref_next(wd);
                    end
                    default: begin
                        m_pred = ref_next(m_pred);
                        if (!counted) begin
                            m_bad = 0;
                        end else begin
                            m_bad++;
                            if (m_bad == 3) begin
                                m_state = 0; m_good = 0; m_bad = 0;
                            end
                        end
                    end
                endcase
            end
        end
        e.lock = (m_state == 2);
        e.err  = counted;
        e.cnt  = NB'(m_cnt);
`ifdef LFSR_CHECK_BITERR_EN
        e.bcnt = NB'(m_bcnt);
`else
        e.bcnt = '0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".lock"}, 32'(bus.o_lock), 32'(e.lock));
        check({tag, ".err"},  32'(bus.o_err),  32'(e.err));
        check({tag, ".cnt"},  32'(bus.o_err_count), 32'(e.cnt));
        check({tag, ".bcnt"}, 32'(bus.o_bit_err_count), 32'(e.bcnt));
    endtask

    task automatic lock_up(input string tag);
        step(1'b0, 1'b1, 8'h01, 1'b0, tag);
        step(1'b0, 1'b1, 8'h02, 1'b0, tag);
        step(1'b0, 1'b1, 8'h04, 1'b0, tag);
        step(1'b0, 1'b1, 8'h08, 1'b0, tag);
        step(1'b0, 1'b1, 8'h10, 1'b0, tag);
        check({tag, ".pre_lock"}, 32'(bus.o_lock), 32'd0);
        step(1'b0, 1'b1, 8'h20, 1'b0, tag);
        check({tag, ".locked"}, 32'(bus.o_lock), 32'd1);
    endtask

    initial begin
        i_rst = 1'b1; bus.i_valid = 1'b0; bus.i_lfsr = 8'h00; bus.i_clr_cnt = 1'b0;
        m_state = 0; m_pred = 8'h00; m_good = 0; m_bad = 0; m_cnt = 0; m_bcnt = 0;

        step(1'b1, 1'b0, 8'h00, 1'b0, "reset");
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset");
        check("reset.lock", 32'(bus.o_lock), 32'd0);
        check("reset.cnt", 32'(bus.o_err_count), 32'd0);

        // Initial lock, then cover the zero word and the wrap from 00.
        lock_up("lock");
        step(1'b0, 1'b1, 8'h40, 1'b0, "stream");
        step(1'b0, 1'b1, 8'h80, 1'b0, "stream");
        step(1'b0, 1'b1, 8'h00, 1'b0, "zero");
        step(1'b0, 1'b1, 8'h8D, 1'b0, "wrap");
        check("wrap.cnt", 32'(bus.o_err_count), 32'd0);
        check("wrap.lock", 32'(bus.o_lock), 32'd1);

        // A single corrupted word: 8C where 8D is expected.
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset2");
        lock_up("relock");
        step(1'b0, 1'b1, 8'h40, 1'b0, "stream2");
        step(1'b0, 1'b1, 8'h80, 1'b0, "stream2");
        step(1'b0, 1'b1, 8'h00, 1'b0, "stream2");
        step(1'b0, 1'b1, 8'h8C, 1'b0, "single_err");
        check("single_err.pulse", 32'(bus.o_err), 32'd1);
        check("single_err.cnt", 32'(bus.o_err_count), 32'd1);
        check("single_err.lock", 32'(bus.o_lock), 32'd1);
        step(1'b0, 1'b1, 8'h97, 1'b0, "after_err");
        check("after_err.pulse", 32'(bus.o_err), 32'd0);

        // Three consecutive mismatches drop lock.
        step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b0, "burst1");
        step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b0, "burst2");
        check("burst2.lock", 32'(bus.o_lock), 32'd1);
        step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b0, "burst3");
        check("burst3.lock", 32'(bus.o_lock), 32'd0);
        check("burst3.cnt", 32'(bus.o_err_count), 32'd4);

        // Relock on a clean stream needs one seed word plus five matches.
        w = 8'h55;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, w, 1'b0, "relock_clean");
            w = ref_next(w);
        end
        check("relock_clean.lock", 32'(bus.o_lock), 32'd1);

        // A mismatch during LOCKING reseeds the prediction; gaps in valid hold state.
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset3");
        step(1'b0, 1'b1, 8'h01, 1'b0, "reseed");
        step(1'b0, 1'b1, 8'h02, 1'b0, "reseed");
        step(1'b0, 1'b1, 8'h55, 1'b0, "reseed");
        step(1'b0, 1'b1, 8'hAA, 1'b0, "reseed");
        step(1'b0, 1'b0, 8'h33, 1'b0, "gap");
        step(1'b0, 1'b0, 8'h00, 1'b0, "gap");
        check("gap.err", 32'(bus.o_err), 32'd0);
        w = ref_next(8'hAA);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, w, 1'b0, "reseed_run");
            w = ref_next(w);
        end
        check("reseed.lock", 32'(bus.o_lock), 32'd1);
        check("reseed.cnt", 32'(bus.o_err_count), 32'd0);

        // Alternate error/good so lock holds while the counter saturates.
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, m_pred ^ 8'h01, 1'b0, "sat_err");
            step(1'b0, 1'b1, m_pred, 1'b0, "sat_ok");
        end
        check("sat.cnt", 32'(bus.o_err_count), 32'hF);
        check("sat.lock", 32'(bus.o_lock), 32'd1);

        step(1'b0, 1'b1, m_pred ^ 8'h01, 1'b1, "clr_err");
        check("clr_err.cnt", 32'(bus.o_err_count), 32'd1);
        step(1'b0, 1'b1, m_pred, 1'b0, "clr_ok");
        step(1'b0, 1'b0, 8'h00, 1'b1, "clr_only");
        check("clr_only.cnt", 32'(bus.o_err_count), 32'd0);
        check("clr_only.lock", 32'(bus.o_lock), 32'd1);

        // Reset while locked, with an error pending in the same cycle.
        step(1'b0, 1'b1, m_pred ^ 8'h01, 1'b0, "pre_rst");
        step(1'b1, 1'b1, m_pred, 1'b0, "mid_rst");
        check("mid_rst.lock", 32'(bus.o_lock), 32'd0);
        check("mid_rst.err", 32'(bus.o_err), 32'd0);
        check("mid_rst.cnt", 32'(bus.o_err_count), 32'd0);
        step(1'b0, 1'b1, 8'h01, 1'b0, "post_rst");
        check("post_rst.lock", 32'(bus.o_lock), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
